// File: rtl/rwave_scan_ctrl.sv
// R-wave peak scanner: reads a window of ECG samples from memory and reports the
// largest sample above threshold (earliest on ties), with window checking and ack timeout.
module rwave_scan_ctrl #(
    parameter int DATA_W  = 16,
    parameter int POS_W   = 12,
    parameter int MAX_WIN = 256,
    parameter int ACK_TMO = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              Enable,
    input  logic              start,
    input  logic [POS_W-1:0]  win_begin,
    input  logic [POS_W-1:0]  win_end,
    input  logic [DATA_W-1:0] thr,
    output logic              mem_req,
    output logic [POS_W-1:0]  mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic [DATA_W-1:0] r_peak,
    output logic [POS_W-1:0]  r_peak_pos,
    output logic              Rp,
    output logic              done,
    output logic              err
);

    localparam int unsigned TMO_W = (ACK_TMO > 1) ? $clog2(ACK_TMO) : 1;
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SCAN, S_DONE} state_t;

    state_t                   state;
    logic [POS_W-1:0]         wb_q;
    logic [POS_W-1:0]         we_q;
    logic [POS_W-1:0]         addr;
    logic [POS_W-1:0]         pos;
    logic signed [DATA_W-1:0] thr_q;
    logic signed [DATA_W-1:0] best;
    logic                     found;
    logic [TMO_W-1:0]         tmo_cnt;
    logic                     req_q;
    logic                     done_q;

    logic [POS_W:0]           win_len;
    logic                     bad_win;
    logic signed [DATA_W-1:0] sample;
    logic                     ack_c;
    logic                     upd_c;
    logic                     found_c;
    logic signed [DATA_W-1:0] best_c;
    logic [POS_W-1:0]         pos_c;

    // Freeze gates the request and completion strobe immediately, not a cycle late
    assign mem_req  = req_q & Enable;
    assign done     = done_q & Enable;
    assign mem_addr = addr;

    // Window check and running-peak update including the sample acked this cycle
    always_comb begin
        win_len = {1'b0, we_q} - {1'b0, wb_q} + (POS_W+1)'(1);
        bad_win = (we_q < wb_q) || (32'(win_len) > 32'(MAX_WIN));
        sample  = $signed(mem_data);
        ack_c   = (state == S_SCAN) && mem_ack;
        upd_c   = ack_c && (sample > thr_q) && (sample > best);
        found_c = found | upd_c;
        best_c  = upd_c ? sample : best;
        pos_c   = upd_c ? addr : pos;
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            wb_q       <= '0;
            we_q       <= '0;
            addr       <= '0;
            pos        <= '0;
            thr_q      <= '0;
            best       <= '0;
            found      <= 1'b0;
            tmo_cnt    <= '0;
            req_q      <= 1'b0;
            done_q     <= 1'b0;
            busy       <= 1'b0;
            r_peak     <= '0;
            r_peak_pos <= '0;
            Rp         <= 1'b0;
            err        <= 1'b0;
        end else if (Enable) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_CHECK;
                        busy  <= 1'b1;
                        wb_q  <= win_begin;
                        we_q  <= win_end;
                        thr_q <= $signed(thr);
                    end
                end
                S_CHECK: begin
                    tmo_cnt <= '0;
                    found   <= 1'b0;
                    if (bad_win) begin
                        state      <= S_DONE;
                        err        <= 1'b1;
                        done_q     <= 1'b1;
                        Rp         <= 1'b0;
                        r_peak     <= '0;
                        r_peak_pos <= '0;
                    end else begin
                        state <= S_SCAN;
                        addr  <= wb_q;
                        best  <= MOST_NEG;
                        err   <= 1'b0;
                        req_q <= 1'b1;
                    end
                end
                S_SCAN: begin
                    if (ack_c) begin
                        tmo_cnt <= '0;
                        best    <= best_c;
                        pos     <= pos_c;
                        found   <= found_c;
                        if (addr == we_q) begin
                            state      <= S_DONE;
                            req_q      <= 1'b0;
                            done_q     <= 1'b1;
                            Rp         <= found_c;
                            r_peak     <= found_c ? best_c : '0;
                            r_peak_pos <= found_c ? pos_c : '0;
                        end else begin
                            addr <= addr + POS_W'(1);
                        end
                    end else if (tmo_cnt == TMO_W'(ACK_TMO - 1)) begin
                        state      <= S_DONE;
                        err        <= 1'b1;
                        found      <= 1'b0;
                        req_q      <= 1'b0;
                        done_q     <= 1'b1;
                        Rp         <= 1'b0;
                        r_peak     <= '0;
                        r_peak_pos <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    done_q <= 1'b0;
                    busy   <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rwave_scan_ctrl.sv
// Bench for rwave_scan_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized scans scored against a window-max reference model.
module tb_rwave_scan_ctrl;

    localparam int DW    = 16;
    localparam int PW    = 12;
    localparam int MW    = 256;
    localparam int TMO   = 15;
    localparam int DEPTH = 1 << PW;

    logic          clk = 1'b0;
    logic          Reset;
    logic          Enable;
    logic          start;
    logic [PW-1:0] win_begin;
    logic [PW-1:0] win_end;
    logic [DW-1:0] thr;
    logic          mem_req;
    logic [PW-1:0] mem_addr;
    logic          mem_ack = 1'b1;
    logic [DW-1:0] mem_data;
    logic          busy;
    logic [DW-1:0] r_peak;
    logic [PW-1:0] r_peak_pos;
    logic          Rp;
    logic          done;
    logic          err;

    logic signed [DW-1:0] smem [0:DEPTH-1];

    int checks    = 0;
    int errors    = 0;
    int ack_mode  = 0;
    int ack_pct   = 100;
    int hold_addr = 0;
    int hold_len  = 0;
    int held      = 0;
    int lows      = 0;

    typedef struct {
        int wb; int we; int t;
        int e_err; int e_rp; int e_pk; int e_ps; int e_lat;
    } vec_t;
    vec_t vecs [9];

    always #5 clk = ~clk;

    assign mem_data = smem[mem_addr];

    rwave_scan_ctrl #(.DATA_W(DW), .POS_W(PW), .MAX_WIN(MW), .ACK_TMO(TMO)) dut (
        .clk(clk), .Reset(Reset), .Enable(Enable), .start(start),
        .win_begin(win_begin), .win_end(win_end), .thr(thr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .busy(busy), .r_peak(r_peak), .r_peak_pos(r_peak_pos), .Rp(Rp),
        .done(done), .err(err)
    );

    // Memory acknowledge: random with bounded droughts, or withheld at one address
    always @(negedge clk) begin
        if (ack_mode == 0) begin
            if (lows >= 10 || $urandom_range(1, 100) <= ack_pct) begin
                mem_ack = 1'b1;
                lows    = 0;
            end else begin
                mem_ack = 1'b0;
                lows++;
            end
        end else begin
            if (!mem_req) held = 0;
            if (mem_req && int'(mem_addr) == hold_addr && held < hold_len) begin
                mem_ack = 1'b0;
                held++;
            end else begin
                mem_ack = 1'b1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected result: largest sample strictly above threshold, first occurrence wins
    function automatic void ref_scan(input int wb, input int we, input int t,
                                     output int e_err, output int e_rp,
                                     output int e_pk, output int e_ps);
        e_err = 0; e_rp = 0; e_pk = 0; e_ps = 0;
        if (we < wb || we - wb + 1 > MW) begin
            e_err = 1;
            return;
        end
        for (int a = wb; a <= we; a++) begin
            int v;
            v = int'(smem[a]);
            if (v > t && (e_rp == 0 || v > e_pk)) begin
                e_rp = 1;
                e_pk = v;
                e_ps = a;
            end
        end
    endfunction

    task automatic run_scan(input int wb, input int we, input int t,
                            input int pause_at, input int pause_len,
                            output int lat, output int saw_req);
        logic [PW-1:0] held_addr;
        int n;
        held_addr = '0;
        lat = 0;
        saw_req = 0;
        @(negedge clk);
        win_begin = PW'(wb);
        win_end   = PW'(we);
        thr       = DW'(t);
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (lat == 0 && n < 3000) begin
            if (mem_req) saw_req = 1;
            if (Enable == 1'b0) begin
                chk("frozen_mem_req", int'(mem_req), 0);
                chk("frozen_addr", int'(mem_addr), int'(held_addr));
                chk("frozen_done", int'(done), 0);
            end else if (n == 1) begin
                chk("busy_in_check", int'(busy), 1);
            end
            if (done) lat = n;
            if (pause_at != 0 && n == pause_at) begin
                Enable    = 1'b0;
                held_addr = mem_addr;
            end else if (pause_at != 0 && n == pause_at + pause_len) begin
                Enable = 1'b1;
            end
            if (lat == 0) begin
                n++;
                @(negedge clk);
            end
        end
        Enable = 1'b1;
        if (lat == 0) begin
            chk("done_timeout", 0, 1);
        end else begin
            @(negedge clk);
            chk("done_pulse_width", int'(done), 0);
            chk("busy_after_done", int'(busy), 0);
        end
    endtask

    task automatic do_case(input string nm, input int wb, input int we, input int t,
                           input int pause_at, input int pause_len,
                           input int e_err, input int e_rp, input int e_pk,
                           input int e_ps, input int e_lat);
        int lat, saw_req;
        run_scan(wb, we, t, pause_at, pause_len, lat, saw_req);
        chk({nm, ".err"}, int'(err), e_err);
        chk({nm, ".Rp"}, int'(Rp), e_rp);
        chk({nm, ".r_peak"}, int'($signed(r_peak)), e_pk);
        chk({nm, ".r_peak_pos"}, int'(r_peak_pos), e_ps);
        chk({nm, ".mem_req_seen"}, saw_req, (e_err == 1 && e_lat == 2) ? 0 : 1);
        if (e_lat > 0) chk({nm, ".latency"}, lat, e_lat);
    endtask

    initial begin
        int e_err, e_rp, e_pk, e_ps;
        Reset = 1'b1; Enable = 1'b1; start = 1'b0;
        win_begin = '0; win_end = '0; thr = '0;
        for (int i = 0; i < DEPTH; i++) smem[i] = '0;
        smem[0] = -16'sd1;
        smem[10] = 16'sd200; smem[11] = 16'sd150; smem[12] = -16'sd300;
        smem[37] = 16'sd500; smem[200] = 16'sd500;
        smem[100] = 16'sd10; smem[101] = 16'sd80; smem[102] = 16'sd120;
        smem[103] = 16'sd120; smem[104] = 16'sd30;
        smem[4095] = 16'sd7;

        //            wb    we    thr     err rp pk   pos   lat
        vecs[0] = '{100,  104,  50,     0,  1, 120, 102,  7};
        vecs[1] = '{10,   12,   -32768, 0,  1, 200, 10,   5};
        vecs[2] = '{50,   40,   0,      1,  0, 0,   0,    2};
        vecs[3] = '{10,   12,   200,    0,  0, 0,   0,    5};
        vecs[4] = '{100,  104,  120,    0,  0, 0,   0,    7};
        vecs[5] = '{0,    256,  0,      1,  0, 0,   0,    2};
        vecs[6] = '{4095, 4095, 6,      0,  1, 7,   4095, 3};
        vecs[7] = '{0,    4095, 0,      1,  0, 0,   0,    2};
        vecs[8] = '{0,    255,  400,    0,  1, 500, 37,   258};

        #2;
        chk("rst.mem_req", int'(mem_req), 0);
        chk("rst.mem_addr", int'(mem_addr), 0);
        chk("rst.busy", int'(busy), 0);
        chk("rst.r_peak", int'(r_peak), 0);
        chk("rst.r_peak_pos", int'(r_peak_pos), 0);
        chk("rst.Rp", int'(Rp), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.err", int'(err), 0);
        repeat (3) @(negedge clk);
        Reset = 1'b0;

        ack_mode = 0; ack_pct = 100;
        for (int i = 0; i < 9; i++)
            do_case($sformatf("vec%0d", i), vecs[i].wb, vecs[i].we, vecs[i].t, 0, 0,
                    vecs[i].e_err, vecs[i].e_rp, vecs[i].e_pk, vecs[i].e_ps, vecs[i].e_lat);

        // Ack withheld at the second address: 15 cycles aborts, 14 cycles survives
        ack_mode = 1; hold_addr = 101; hold_len = 15;
        do_case("tmo15", 100, 104, 50, 0, 0, 1, 0, 0, 0, 18);
        hold_len = 14;
        do_case("tmo14", 100, 104, 50, 0, 0, 0, 1, 120, 102, 21);

        // Enable low for 5 cycles mid-scan
        ack_mode = 0; ack_pct = 100;
        do_case("pause_ack_hi", 100, 104, 50, 4, 5, 0, 1, 120, 102, 12);
        ack_pct = 60;
        do_case("pause_ack_rnd", 100, 104, 50, 4, 5, 0, 1, 120, 102, -1);

        // Reset mid-scan, then a fresh single-sample scan
        ack_pct = 100;
        @(negedge clk);
        win_begin = PW'(100); win_end = PW'(104); thr = DW'(50); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("midrst.mem_req", int'(mem_req), 0);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.Rp", int'(Rp), 0);
        chk("midrst.r_peak", int'(r_peak), 0);
        chk("midrst.mem_addr", int'(mem_addr), 0);
        @(negedge clk);
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("midrst.no_stale_done", int'(done), 0);
        end
        do_case("post_rst", 0, 0, -5, 0, 0, 0, 1, -1, 0, 3);

        // Randomized scans against the reference model
        for (int it = 0; it < 40; it++) begin
            int r, len, wb, we, t, pa, pl, e_lat;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                wb = $urandom_range(20, DEPTH - 1);
                we = wb - $urandom_range(1, 19);
            end else if (r == 1) begin
                len = $urandom_range(MW + 1, MW + 44);
                wb  = $urandom_range(0, DEPTH - 300);
                we  = wb + len - 1;
            end else begin
                len = $urandom_range(1, 30);
                wb  = $urandom_range(0, DEPTH - len);
                we  = wb + len - 1;
                for (int a = wb; a <= we; a++)
                    smem[a] = DW'($urandom_range(0, 40) * 100 - 2000);
            end
            t = $urandom_range(0, 40) * 100 - 2000;
            ack_pct = ($urandom_range(0, 2) == 0) ? 100 : $urandom_range(50, 99);
            pa = 0; pl = 0;
            if (r > 1 && $urandom_range(0, 2) == 0) begin
                pa = $urandom_range(2, we - wb + 2);
                pl = $urandom_range(1, 6);
            end
            ref_scan(wb, we, t, e_err, e_rp, e_pk, e_ps);
            if (e_err == 1) e_lat = 2;
            else if (ack_pct == 100) e_lat = we - wb + 1 + 2 + pl;
            else e_lat = -1;
            do_case($sformatf("rnd%0d", it), wb, we, t, pa, pl, e_err, e_rp, e_pk, e_ps, e_lat);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rwave_scan_ctrl.md
RWAVE_SCAN_CTRL -- requirements
Module: rwave_scan_ctrl

Interface
REQ-001: Parameter DATA_W, default 16, sample and threshold width (two's complement signed).
REQ-002: Parameter POS_W, default 12, sample-position / address width.
REQ-003: Parameter MAX_WIN, default 256, maximum legal window length in samples.
REQ-004: Parameter ACK_TMO, default 15, cycles allowed for mem_ack before abort.
REQ-005: clk  in  1  single clock; all state changes on its rising edge.
REQ-006: Reset  in  1  asynchronous, active-high; clears all state when high.
REQ-007: Enable  in  1  when low, freezes FSM, counters and outputs.
REQ-008: start  in  1  begin a scan; sampled only in IDLE with Enable high.
REQ-009: win_begin  in  POS_W  first sample position of QRS search window.
REQ-010: win_end  in  POS_W  last sample position of QRS search window (inclusive).
REQ-011: thr  in  DATA_W  signed R-peak amplitude threshold.
REQ-012: mem_req  out  1  sample read request to sample memory.
REQ-013: mem_addr  out  POS_W  address of requested sample.
REQ-014: mem_ack  in  1  sample-memory acknowledge; mem_data valid in the same cycle.
REQ-015: mem_data  in  DATA_W  signed sample returned by memory.
REQ-016: busy  out  1  high in every state except IDLE.
REQ-017: r_peak  out  DATA_W  amplitude of detected R peak.
REQ-018: r_peak_pos  out  POS_W  position of detected R peak.
REQ-019: Rp  out  1  R peak found in last completed scan (level).
REQ-020: done  out  1  one-cycle pulse marking scan completion.
REQ-021: err  out  1  last scan aborted (bad window or ack timeout) (level).

Function
REQ-022: FSM states IDLE, CHECK, SCAN, DONE; encoding is free.
REQ-023: IDLE -> CHECK when start and Enable are high; win_begin, win_end and thr are latched on that edge.
REQ-024: start while busy is ignored; latched window/threshold do not change during a scan.
REQ-025: CHECK: if win_end < win_begin or (win_end - win_begin + 1) > MAX_WIN, set err=1 and go to DONE without any mem_req; otherwise set addr=win_begin, best=most-negative DATA_W value, found=0, clear err, go to SCAN.
REQ-026: SCAN: mem_req=1 and mem_addr=addr, held stable until a cycle with mem_ack high.
REQ-027: On a mem_ack cycle: if mem_data > thr and mem_data > best (both signed, strict), then best<=mem_data, pos<=addr, found<=1.
REQ-028: Equal amplitudes keep the earliest position; samples equal to thr are never peaks.
REQ-029: After an ack at addr==win_end, go to DONE; otherwise addr<=addr+1 and stay in SCAN, so back-to-back acks give one sample per cycle.
REQ-030: A timeout counter clears on each ack and on entry to SCAN; after ACK_TMO consecutive SCAN cycles with no ack, set err=1, found=0 and go to DONE.
REQ-031: DONE lasts exactly one cycle, then goes to IDLE; during DONE, done=1 and mem_req=0.
REQ-032: On entry to DONE (registered), Rp<=found, r_peak<=found ? best : 0, r_peak_pos<=found ? pos : 0; these hold until the next DONE.
REQ-033: Latency with mem_ack tied high: start sampled at edge k, done high in cycle k+N+2, where N = window length.
REQ-034: Enable low: FSM state, addr, best, timeout counter and outputs hold; mem_req is forced to 0; mem_ack is ignored; done is not asserted during a frozen DONE cycle and is delayed until Enable returns.
REQ-035: Position arithmetic is unsigned POS_W; window length is computed in POS_W+1 bits, so win_end=2^POS_W-1 does not wrap.

Reset
REQ-036: While Reset is high, regardless of clk: state=IDLE, mem_req=0, mem_addr=0, busy=0, r_peak=0, r_peak_pos=0, Rp=0, done=0, err=0, internal counters=0.
REQ-037: Reset asserted mid-scan aborts the scan immediately; no done pulse is produced, and the first start after release is accepted normally.

Verification
REQ-038: Ack tied high, win 100..104, thr=50, samples 10,80,120,120,30 -> done at start+7, Rp=1, r_peak=120, r_peak_pos=102, err=0.
REQ-039: Win 10..12, thr=200, all samples <=200 (incl. one =200) -> Rp=0, r_peak=0, r_peak_pos=0, err=0.
REQ-040: win_begin=50, win_end=40; separately win 0..256 -> no mem_req, done at start+2, err=1, Rp=0.
REQ-041: Ack withheld 15 cycles at the second address -> err=1, Rp=0, done one cycle later; ack at cycle 14 instead -> scan continues normally.
REQ-042: Enable low for 5 cycles mid-SCAN with a random ack -> mem_req=0, addr held, result identical to the uninterrupted run, done delayed by 5.
REQ-043: Reset pulse during SCAN, then new start with win 0..0 and sample -1 > thr=-5 -> no stale done, Rp=1, r_peak=-1, r_peak_pos=0.
